// File: rtl/bp_cfg_link_responder.sv
// Per-tile cfg link endpoint: filters requests by core id, holds config regs.
// Optional BP_CFG_LINK_BROADCAST_EN: all-ones core id writes hit every tile silently.
module bp_cfg_link_responder #(
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int vaddr_width_p    = 39,
  parameter logic [vaddr_width_p-1:0] npc_reset_p = 39'h00_8000_0000
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [cfg_core_width_p-1:0] my_core_id_i,
  input  logic                        cfg_v_i,
  output logic                        cfg_ready_o,
  input  logic                        cfg_w_i,
  input  logic [cfg_core_width_p-1:0] cfg_core_i,
  input  logic [cfg_addr_width_p-1:0] cfg_addr_i,
  input  logic [cfg_data_width_p-1:0] cfg_data_i,
  output logic                        resp_v_o,
  input  logic                        resp_ready_i,
  output logic [cfg_data_width_p-1:0] resp_data_o,
  output logic                        resp_err_o,
  output logic                        freeze_o,
  output logic [cfg_core_width_p-1:0] core_id_o,
  output logic [1:0]                  icache_mode_o,
  output logic [1:0]                  dcache_mode_o,
  output logic                        cce_mode_o,
  output logic [vaddr_width_p-1:0]    npc_o,
  output logic                        npc_w_o
);

  localparam int hi_w = vaddr_width_p - 32;

  typedef enum logic {READY, RESP} state_e;

  state_e state_r, state_n;

  logic        accept, match;
  logic        hit_wr, hit_resp, do_wr;
  logic        mapped;
  logic [cfg_data_width_p-1:0] rd_data;
  logic [31:0] npc_lo_r;

  logic sel_freeze, sel_core, sel_ic, sel_dc;
  logic sel_cce, sel_lo, sel_hi;

  assign sel_freeze = cfg_addr_i == cfg_addr_width_p'(16'h0001);
  assign sel_core   = cfg_addr_i == cfg_addr_width_p'(16'h0002);
  assign sel_ic     = cfg_addr_i == cfg_addr_width_p'(16'h0003);
  assign sel_dc     = cfg_addr_i == cfg_addr_width_p'(16'h0004);
  assign sel_cce    = cfg_addr_i == cfg_addr_width_p'(16'h0005);
  assign sel_lo     = cfg_addr_i == cfg_addr_width_p'(16'h0010);
  assign sel_hi     = cfg_addr_i == cfg_addr_width_p'(16'h0011);

  assign accept = cfg_v_i & cfg_ready_o;
  assign match  = cfg_core_i == my_core_id_i;

`ifdef BP_CFG_LINK_BROADCAST_EN
  logic all_ones;
  assign all_ones = &cfg_core_i;
  // Broadcast reads fall out as non-matching: no write, no response.
  assign hit_wr   = all_ones ? cfg_w_i : match;
  assign hit_resp = match & ~all_ones;
`else
  assign hit_wr   = match;
  assign hit_resp = match;
`endif

  assign do_wr = accept & cfg_w_i & hit_wr;

  always_comb begin
    rd_data = '0;
    mapped  = 1'b1;
    unique case (1'b1)
      sel_freeze: rd_data = cfg_data_width_p'(freeze_o);
      sel_core:   rd_data = cfg_data_width_p'(core_id_o);
      sel_ic:     rd_data = cfg_data_width_p'(icache_mode_o);
      sel_dc:     rd_data = cfg_data_width_p'(dcache_mode_o);
      sel_cce:    rd_data = cfg_data_width_p'(cce_mode_o);
      sel_lo:     rd_data = cfg_data_width_p'(npc_o[31:0]);
      sel_hi:     rd_data = cfg_data_width_p'(npc_o[vaddr_width_p-1:32]);
      default:    mapped  = 1'b0;
    endcase
  end

  always_comb begin
    state_n     = state_r;
    cfg_ready_o = 1'b0;
    resp_v_o    = 1'b0;
    unique case (state_r)
      READY: begin
        cfg_ready_o = 1'b1;
        if (accept && hit_resp) state_n = RESP;
      end
      RESP: begin
        resp_v_o = 1'b1;
        if (resp_ready_i) state_n = READY;
      end
      default: state_n = READY;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= READY;
    else            state_r <= state_n;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_data_o <= '0;
      resp_err_o  <= 1'b0;
    end else if (accept && hit_resp) begin
      resp_data_o <= cfg_w_i ? '0 : rd_data;
      resp_err_o  <= ~mapped;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      freeze_o      <= 1'b1;
      core_id_o     <= '0;
      icache_mode_o <= '0;
      dcache_mode_o <= '0;
      cce_mode_o    <= 1'b0;
      npc_o         <= npc_reset_p;
      npc_lo_r      <= '0;
      npc_w_o       <= 1'b0;
    end else begin
      npc_w_o <= 1'b0;
      if (do_wr) begin
        unique case (1'b1)
          sel_freeze: freeze_o      <= cfg_data_i[0];
          sel_core:   core_id_o     <= cfg_data_i[cfg_core_width_p-1:0];
          sel_ic:     icache_mode_o <= cfg_data_i[1:0];
          sel_dc:     dcache_mode_o <= cfg_data_i[1:0];
          sel_cce:    cce_mode_o    <= cfg_data_i[0];
          sel_lo:     npc_lo_r      <= cfg_data_i[31:0];
          sel_hi: begin
            npc_o   <= {cfg_data_i[hi_w-1:0], npc_lo_r};
            npc_w_o <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bp_cfg_link_responder.sv
// Scoreboard bench for bp_cfg_link_responder: directed plan plus random traffic.
// Reference model is a plain register array updated per accepted request.
module tb_bp_cfg_link_responder;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b1;
  logic [7:0]  my_core_id_i = 8'd3;
  logic        cfg_v_i = 1'b0;
  logic        cfg_ready_o;
  logic        cfg_w_i = 1'b0;
  logic [7:0]  cfg_core_i = '0;
  logic [15:0] cfg_addr_i = '0;
  logic [31:0] cfg_data_i = '0;
  logic        resp_v_o;
  logic        resp_ready_i = 1'b1;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic        freeze_o;
  logic [7:0]  core_id_o;
  logic [1:0]  icache_mode_o;
  logic [1:0]  dcache_mode_o;
  logic        cce_mode_o;
  logic [38:0] npc_o;
  logic        npc_w_o;

  bp_cfg_link_responder dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .my_core_id_i(my_core_id_i),
    .cfg_v_i(cfg_v_i), .cfg_ready_o(cfg_ready_o), .cfg_w_i(cfg_w_i),
    .cfg_core_i(cfg_core_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .freeze_o(freeze_o), .core_id_o(core_id_o),
    .icache_mode_o(icache_mode_o), .dcache_mode_o(dcache_mode_o),
    .cce_mode_o(cce_mode_o), .npc_o(npc_o), .npc_w_o(npc_w_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   hold_ready = 1'b0;

  logic        m_freeze;
  logic [7:0]  m_core_id;
  logic [1:0]  m_ic, m_dc;
  logic        m_cce;
  logic [38:0] m_npc;
  logic [31:0] m_lo;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_freeze = 1'b1; m_core_id = '0; m_ic = '0; m_dc = '0;
    m_cce = 1'b0; m_npc = 39'h00_8000_0000; m_lo = '0;
  endtask

  // Applies one accepted request to the model; returns response and npc pulse.
  task automatic model_accept(input logic w, input logic [7:0] core,
                              input logic [15:0] addr, input logic [31:0] data,
                              output logic resp, output exp_t e,
                              output logic pulse);
    logic bcast, wr;
    logic [31:0] rd;
    logic err;
    bcast = 1'b0;
`ifdef BP_CFG_LINK_BROADCAST_EN
    bcast = (core == 8'hFF);
`endif
    if (bcast) begin
      wr = w; resp = 1'b0;
    end else begin
      wr = w && (core == my_core_id_i);
      resp = (core == my_core_id_i);
    end
    err = 1'b0; rd = '0;
    case (addr)
      16'h0001: rd = {31'b0, m_freeze};
      16'h0002: rd = {24'b0, m_core_id};
      16'h0003: rd = {30'b0, m_ic};
      16'h0004: rd = {30'b0, m_dc};
      16'h0005: rd = {31'b0, m_cce};
      16'h0010: rd = m_npc[31:0];
      16'h0011: rd = {25'b0, m_npc[38:32]};
      default:  err = 1'b1;
    endcase
    pulse = 1'b0;
    if (wr) begin
      case (addr)
        16'h0001: m_freeze = data[0];
        16'h0002: m_core_id = data[7:0];
        16'h0003: m_ic = data[1:0];
        16'h0004: m_dc = data[1:0];
        16'h0005: m_cce = data[0];
        16'h0010: m_lo = data;
        16'h0011: begin m_npc = {data[6:0], m_lo}; pulse = 1'b1; end
        default: ;
      endcase
    end
    e.data = w ? 32'h0 : rd;
    e.err  = err;
  endtask

  task automatic check_regs();
    chk("freeze", freeze_o, m_freeze);
    chk("core_id", core_id_o, m_core_id);
    chk("icache_mode", icache_mode_o, m_ic);
    chk("dcache_mode", dcache_mode_o, m_dc);
    chk("cce_mode", cce_mode_o, m_cce);
    chk("npc", npc_o, m_npc);
  endtask

  task automatic send(input logic w, input logic [7:0] core,
                      input logic [15:0] addr, input logic [31:0] data);
    int n;
    logic resp, pulse;
    exp_t e;
    n = 0;
    @(negedge clk_i);
    while (!cfg_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!cfg_ready_o) begin
      chk("ready_timeout", {63'b0, cfg_ready_o}, 64'd1);
      return;
    end
    cfg_v_i = 1'b1; cfg_w_i = w; cfg_core_i = core;
    cfg_addr_i = addr; cfg_data_i = data;
    model_accept(w, core, addr, data, resp, e, pulse);
    if (resp) exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    cfg_v_i = 1'b0;
    check_regs();
    chk("npc_w", npc_w_o, pulse);
    chk("cfg_ready_after", cfg_ready_o, !resp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk_i);
    while ((exp_q.size() != 0 || resp_v_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: every cycle a response is visible it must match the queue head.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (!hold_ready) resp_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk_i);
      if (reset_n_i && resp_v_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", {63'b0, resp_v_o}, 64'd0);
        end else begin
          chk("resp_data", resp_data_o, exp_q[0].data);
          chk("resp_err", resp_err_o, exp_q[0].err);
          chk("ready_in_resp", cfg_ready_o, 1'b0);
          if (resp_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0]  core;
    logic [15:0] addr;
    model_reset();
    #3 reset_n_i = 1'b0;
    #1;
    chk("rst_freeze", freeze_o, 1'b1);
    chk("rst_npc", npc_o, 39'h00_8000_0000);
    chk("rst_cfg_ready", cfg_ready_o, 1'b1);
    chk("rst_resp_v", resp_v_o, 1'b0);
    chk("rst_npc_w", npc_w_o, 1'b0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    send(1'b1, 8'd3, 16'h0001, 32'h0);
    send(1'b1, 8'd2, 16'h0001, 32'h1);
    drain();

    send(1'b1, 8'd3, 16'h0010, 32'h1234_5678);
    send(1'b0, 8'd3, 16'h0010, 32'h0);
    send(1'b1, 8'd3, 16'h0011, 32'h7F);
    @(posedge clk_i);
    #1;
    chk("npc_w_single", npc_w_o, 1'b0);
    chk("npc_value", npc_o, 39'h7F_1234_5678);
    send(1'b0, 8'd3, 16'h0011, 32'h0);

    send(1'b0, 8'd3, 16'h00FF, 32'h0);
    send(1'b1, 8'd3, 16'h00FF, 32'hFFFF_FFFF);

    send(1'b1, 8'd3, 16'h0004, 32'h2);
    drain();
    hold_ready = 1'b1;
    resp_ready_i = 1'b0;
    send(1'b0, 8'd3, 16'h0004, 32'h0);
    repeat (5) begin
      @(negedge clk_i);
      chk("stall_resp_v", resp_v_o, 1'b1);
      chk("stall_data", resp_data_o, 32'h2);
      chk("stall_cfg_ready", cfg_ready_o, 1'b0);
    end
    @(posedge clk_i);
    #2 resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("release_resp_v", resp_v_o, 1'b0);
    chk("release_cfg_ready", cfg_ready_o, 1'b1);
    hold_ready = 1'b0;

    send(1'b1, 8'hFF, 16'h0003, 32'h1);
    drain();

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: core = 8'd2;
        1: core = 8'hFF;
        default: core = 8'd3;
      endcase
      case ($urandom_range(0, 8))
        0: addr = 16'h0001;
        1: addr = 16'h0002;
        2: addr = 16'h0003;
        3: addr = 16'h0004;
        4: addr = 16'h0005;
        5: addr = 16'h0010;
        6: addr = 16'h0011;
        7: addr = 16'h00FF;
        default: addr = 16'($urandom);
      endcase
      send(1'($urandom), core, addr, $urandom);
    end
    drain();

    hold_ready = 1'b1;
    resp_ready_i = 1'b0;
    send(1'b0, 8'd3, 16'h0001, 32'h0);
    @(posedge clk_i);
    #2 reset_n_i = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    chk("midrst_resp_v", resp_v_o, 1'b0);
    chk("midrst_cfg_ready", cfg_ready_o, 1'b1);
    check_regs();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    hold_ready = 1'b0;
    send(1'b0, 8'd3, 16'h0005, 32'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_cfg_link_responder.md
Name: bp_cfg_link_responder

Overview:
- Per-tile endpoint of the configuration link.
- Accepts config read/write requests from the host-side loader, filters them by core id, and holds the tile's config registers.
- Registers cover freeze, core id, cache modes, CCE mode and boot NPC; each accepted request gets one response.
- Sits between the cfg link and the core/CCE; register outputs drive those blocks directly.

Parameters:
- cfg_core_width_p, 8, core-select field width
- cfg_addr_width_p, 16, register address width
- cfg_data_width_p, 32, data width; must be >= vaddr_width_p-32 and >= cfg_core_width_p
- vaddr_width_p, 39, boot NPC width
- npc_reset_p, 39'h00_8000_0000, NPC reset value

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- my_core_id_i  in  cfg_core_width_p  static tile id; sampled on every request
- cfg_v_i  in  1  request valid
- cfg_ready_o  out  1  request ready
- cfg_w_i  in  1  1=write, 0=read
- cfg_core_i  in  cfg_core_width_p  target core
- cfg_addr_i  in  cfg_addr_width_p  register address
- cfg_data_i  in  cfg_data_width_p  write data
- resp_v_o  out  1  response valid
- resp_ready_i  in  1  response ready
- resp_data_o  out  cfg_data_width_p  read data, zero-extended; 0 for writes
- resp_err_o  out  1  unmapped address
- freeze_o  out  1  core freeze
- core_id_o  out  cfg_core_width_p  programmed core id
- icache_mode_o  out  2  I$ mode
- dcache_mode_o  out  2  D$ mode
- cce_mode_o  out  1  CCE mode (0 uncached, 1 normal)
- npc_o  out  vaddr_width_p  boot PC
- npc_w_o  out  1  one-cycle pulse when npc_o changes

Behaviour:
- Reset is asynchronous (on reset_n_i low), regardless of clock. Reset values:
  - state=READY, cfg_ready_o=1, resp_v_o=0, resp_data_o=0, resp_err_o=0
  - freeze_o=1, core_id_o=0, icache_mode_o=0, dcache_mode_o=0, cce_mode_o=0
  - npc_o=npc_reset_p, npc_lo staging=0, npc_w_o=0
- FSM has two states, READY and RESP:
  - cfg_ready_o = (state==READY).
  - A request is accepted on cfg_v_i&cfg_ready_o.
  - Accepted with cfg_core_i==my_core_id_i: side effect applied at that clock edge; state->RESP; resp_v_o=1 the next cycle (1-cycle latency).
  - Accepted with cfg_core_i!=my_core_id_i: silently consumed; no response; stays READY.
  - RESP: resp_v_o, resp_data_o and resp_err_o are held stable until resp_ready_i. On that handshake state->READY and resp_v_o=0.
  - cfg_ready_o is low throughout RESP, so peak throughput is one request per 2 cycles.
- Register map (addresses are in cfg_addr_i space; writes take the low bits; reads zero-extend):
  - 0x0001 freeze[0]
  - 0x0002 core_id
  - 0x0003 icache_mode[1:0]
  - 0x0004 dcache_mode[1:0]
  - 0x0005 cce_mode[0]
  - 0x0010 npc_lo[31:0]: staging only; npc_o is unchanged.
  - 0x0011 npc_hi[vaddr_width_p-33:0]: npc_o <= {hi, npc_lo staging}; npc_w_o pulses the following cycle.
- Reads of 0x0010 and 0x0011 return the corresponding bits of npc_o, not the staging register.
- Any other address:
  - write: no register change
  - read: data 0
  - both: resp_err_o=1
- Write responses: resp_data_o=0, resp_err_o=0 for mapped addresses.
- Register outputs update at the accepting clock edge and are visible in the same cycle resp_v_o rises.
- resp_v_o=1 with resp_ready_i=1 in the same cycle: response completes; the next request can be accepted in the following cycle.
- Reset mid-RESP: pending response is dropped; all registers return to reset values.

Optional Feature:
- Macro: BP_CFG_LINK_BROADCAST_EN.
- Defined:
  - cfg_core_i all-ones is treated as matching, for writes only.
  - Broadcast writes update registers but produce no response; the block stays READY.
  - Broadcast reads are treated as non-matching (consumed, no response).
- Undefined: all-ones matches only when my_core_id_i is all-ones, and then behaves as a normal request.

Test Plan:
- Reset -> freeze_o=1, npc_o=0x80000000, cfg_ready_o=1, resp_v_o=0; assert reset_n_i mid-RESP -> resp_v_o=0 immediately, freeze_o=1.
- my_core_id_i=3:
  - write core 3, addr 0x0001, data 0 -> next cycle resp_v_o=1, resp_data_o=0, resp_err_o=0, freeze_o=0.
  - write core 2 -> no response, freeze_o unchanged, cfg_ready_o stays 1.
- Write 0x0010=0x1234_5678, read 0x0010 -> data returns the old npc_o low bits. Then write 0x0011=0x7F -> npc_o=0x7F_1234_5678 with a single npc_w_o pulse; read 0x0011 -> 0x7F.
- Read addr 0x00FF -> resp_err_o=1, resp_data_o=0; write 0x00FF -> resp_err_o=1, no register changes.
- Hold resp_ready_i=0 for 5 cycles after a read of 0x0004 (dcache_mode=2) -> resp_v_o and data 2 held stable, cfg_ready_o=0 throughout; release -> READY next cycle.
- With BP_CFG_LINK_BROADCAST_EN: write core 0xFF addr 0x0003 data 1 -> icache_mode_o=1, no resp_v_o. Without the macro, my_core_id_i=3 -> no change.
